// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetcher with a DEPTH-entry prefetch queue
// feeding registered instruction/pcDir/inst_valid outputs; branch_taken flushes everything.
module fetch_unit #(
   parameter int              ibus     = 32,
   parameter int              mbus     = 32,
   parameter int              DEPTH    = 4,
   parameter logic [mbus-1:0] RESET_PC = '0,
   parameter logic [ibus-1:0] NOP_INST = '0
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req,
   output logic [mbus-1:0] imem_addr,
   input  logic            imem_ready,
   input  logic            imem_valid,
   input  logic [ibus-1:0] imem_data,
   input  logic            branch_taken,
   input  logic [mbus-1:0] branch_target,
   input  logic            stall,
   output logic [ibus-1:0] instruction,
   output logic [mbus-1:0] pcDir,
   output logic            inst_valid
);

   localparam int              AW      = $clog2(DEPTH);
   localparam logic [AW:0]     FULL    = (AW+1)'(DEPTH);
   localparam logic [AW:0]     CNT_ONE = (AW+1)'(1);
   localparam logic [AW-1:0]   PTR_ONE = AW'(1);
   localparam logic [mbus-1:0] PC_STEP = mbus'(4);

   logic [mbus-1:0] fetch_pc_q, fetch_pc_d;
   logic [mbus-1:0] req_pc_q, req_pc_d;
   logic [mbus-1:0] pc_dir_q, pc_dir_d;
   logic [ibus-1:0] instruction_q, instruction_d;
   logic            inst_valid_q, inst_valid_d;
   logic            outstanding_q, outstanding_d;
   logic            discard_q, discard_d;
   logic            redirect_q, redirect_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [AW:0]     count_q, count_d;

   logic [mbus-1:0] pc_mem_q    [DEPTH];
   logic [ibus-1:0] instr_mem_q [DEPTH];

   logic accept;
   logic resp;
   logic push;
   logic pop;

   // redirect_q holds the request off for the cycle after a flush so a pending request is withdrawn
   assign imem_req    = ~rst & ~outstanding_q & ~discard_q & ~redirect_q & (count_q < FULL);
   assign imem_addr   = fetch_pc_q;
   assign instruction = instruction_q;
   assign pcDir       = pc_dir_q;
   assign inst_valid  = inst_valid_q;

   // Next-state computation for fetch tracking, queue pointers and output registers
   always_comb begin
      fetch_pc_d    = fetch_pc_q;
      req_pc_d      = req_pc_q;
      outstanding_d = outstanding_q;
      discard_d     = discard_q;
      redirect_d    = 1'b0;
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      count_d       = count_q;
      pc_dir_d      = pc_dir_q;
      instruction_d = instruction_q;
      inst_valid_d  = inst_valid_q;

      accept = imem_req & imem_ready;
      resp   = imem_valid & outstanding_q;
      push   = resp & ~discard_q & ~branch_taken;
      pop    = ~branch_taken & ~stall & (count_q != '0);

      if (resp) begin
         outstanding_d = 1'b0;
         discard_d     = 1'b0;
      end else begin
         outstanding_d = outstanding_q;
      end

      if (accept) begin
         outstanding_d = 1'b1;
         req_pc_d      = fetch_pc_q;
         fetch_pc_d    = fetch_pc_q + PC_STEP;
      end else begin
         req_pc_d      = req_pc_q;
      end

      if (branch_taken) begin
         // Anything still in flight after this edge belongs to the old path
         discard_d     = outstanding_d;
         fetch_pc_d    = branch_target;
         redirect_d    = 1'b1;
         wr_ptr_d      = '0;
         rd_ptr_d      = '0;
         count_d       = '0;
         instruction_d = NOP_INST;
         inst_valid_d  = 1'b0;
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
         if (stall) begin
            inst_valid_d = inst_valid_q;
         end else if (pop) begin
            instruction_d = instr_mem_q[rd_ptr_q];
            pc_dir_d      = pc_mem_q[rd_ptr_q];
            inst_valid_d  = 1'b1;
         end else begin
            instruction_d = NOP_INST;
            inst_valid_d  = 1'b0;
         end
      end
   end

   // Control and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc_q    <= RESET_PC;
         req_pc_q      <= '0;
         outstanding_q <= 1'b0;
         discard_q     <= 1'b0;
         redirect_q    <= 1'b0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         pc_dir_q      <= '0;
         instruction_q <= NOP_INST;
         inst_valid_q  <= 1'b0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         req_pc_q      <= req_pc_d;
         outstanding_q <= outstanding_d;
         discard_q     <= discard_d;
         redirect_q    <= redirect_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         pc_dir_q      <= pc_dir_d;
         instruction_q <= instruction_d;
         inst_valid_q  <= inst_valid_d;
      end
   end

   // Queue storage; contents are only meaningful between the pointers
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem_q[wr_ptr_q]    <= req_pc_q;
         instr_mem_q[wr_ptr_q] <= imem_data;
      end else begin
         pc_mem_q[wr_ptr_q]    <= pc_mem_q[wr_ptr_q];
         instr_mem_q[wr_ptr_q] <= instr_mem_q[wr_ptr_q];
      end
   end

endmodule
